// File: rtl/strip_frame_scheduler.sv
// Frame sequencer for one LED strip: walks every LED (read, encode, wait done), then holds the latch gap.
// Shares the single memory port with UART writes. Define WRITE_FRAME_LOCK_EN to block writes during a frame.
module strip_frame_scheduler #(
    parameter int NUM_LEDS     = 144,
    parameter int ADDR_WIDTH   = 9,
    parameter int LATCH_CYCLES = 960
) (
    input  logic                  clock_12mhz,
    input  logic                  reset_n,
    input  logic                  framerate,
    input  logic                  write_request,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [23:0]           write_data,
    output logic                  write_ack,
    output logic                  perform_read,
    output logic                  perform_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [23:0]           mem_write_data,
    input  logic                  read_data_ready,
    output logic                  encoder_start,
    input  logic                  encoder_finished,
    output logic [ADDR_WIDTH-1:0] led_counter,
    output logic                  frame_busy,
    output logic [7:0]            overrun_count
);

    localparam int LATCH_WIDTH = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_LED = ADDR_WIDTH'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        WAIT_DONE,
        LATCH
    } state_t;

    state_t                 state;
    logic [LATCH_WIDTH-1:0] latch_count;
    logic [2:0]             finished_sync;
    logic                   done;
    logic                   write_allowed;

    // Two flops cross from the encoder clock; the third only remembers the last value for edge detection.
    assign done = finished_sync[1] & ~finished_sync[2];

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            latch_count   <= '0;
            finished_sync <= '0;
            perform_read  <= 1'b0;
            encoder_start <= 1'b0;
            led_counter   <= '0;
            frame_busy    <= 1'b0;
            overrun_count <= '0;
        end else begin
            finished_sync <= {finished_sync[1:0], encoder_finished};
            perform_read  <= 1'b0;
            encoder_start <= 1'b0;

            if (framerate && state != IDLE && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (framerate) begin
                        state        <= FETCH;
                        led_counter  <= '0;
                        frame_busy   <= 1'b1;
                        perform_read <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (read_data_ready) begin
                        encoder_start <= 1'b1;
                        state         <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        if (led_counter == LAST_LED) begin
                            latch_count <= LATCH_WIDTH'(LATCH_CYCLES - 1);
                            state       <= LATCH;
                        end else begin
                            led_counter  <= led_counter + ADDR_WIDTH'(1);
                            perform_read <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                LATCH: begin
                    if (latch_count == '0) begin
                        state       <= IDLE;
                        frame_busy  <= 1'b0;
                        led_counter <= '0;
                    end else begin
                        latch_count <= latch_count - LATCH_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WRITE_FRAME_LOCK_EN
    // The framerate cycle already counts as busy so a coincident write cannot tear the new frame.
    assign write_allowed = ~frame_busy & ~framerate;
`else
    assign write_allowed = 1'b1;
`endif

    // Reads are registered strobes, so a write simply fills every cycle the read strobe leaves free.
    assign write_ack      = write_request & reset_n & ~perform_read & write_allowed;
    assign perform_write  = write_ack;
    assign mem_address    = perform_read ? led_counter : (write_ack ? write_address : '0);
    assign mem_write_data = write_ack ? write_data : '0;

endmodule

// File: doc/strip_frame_scheduler.md
Name: strip_frame_scheduler

Overview:
- Sequences one LED strip refresh per frame tick and shares the single LED memory port between the UART write path and the frame readout.
- Per frame, walks LED addresses 0..NUM_LEDS-1: read memory, start encoder, wait for encoder done. Then holds the strip-latch gap.
- Sits between uart_handler, memory and encoder_xx6812, replacing ad-hoc read timing.

Parameters:
- NUM_LEDS, 144, LEDs per strip (1..511).
- ADDR_WIDTH, 9, memory address width.
- LATCH_CYCLES, 960, clock_12mhz cycles of idle line after the last LED (80 us).

Ports:
- clock_12mhz  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- framerate  input  1  one-cycle frame-start pulse.
- write_request  input  1  UART side wants a write; held until write_ack.
- write_address  input  ADDR_WIDTH  UART write address.
- write_data  input  24  UART write data.
- write_ack  output  1  one-cycle pulse when the write is issued to memory.
- perform_read  output  1  memory read strobe.
- perform_write  output  1  memory write strobe.
- mem_address  output  ADDR_WIDTH  memory address (read or write).
- mem_write_data  output  24  memory write data.
- read_data_ready  input  1  memory read data valid pulse.
- encoder_start  output  1  one-cycle encoder load/start pulse.
- encoder_finished  input  1  encoder done level, from the bit_segment_clock domain.
- led_counter  output  ADDR_WIDTH  index of the LED currently being processed.
- frame_busy  output  1  high from frame start to end of latch.
- overrun_count  output  8  saturating count of framerate pulses ignored while busy.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All strobes 0, led_counter 0, frame_busy 0, overrun_count 0, mem_address 0, mem_write_data 0, sync flops 0.
- encoder_finished passes through a 2-flop synchroniser. "done" means a rising edge of the synchronised signal.
- IDLE: on framerate go to FETCH with led_counter=0 and frame_busy=1.
- FETCH: assert perform_read for exactly 1 cycle with mem_address=led_counter, then go to WAIT_DATA.
- WAIT_DATA: on read_data_ready, pulse encoder_start the next cycle, then go to WAIT_DONE.
- WAIT_DONE: on done, if led_counter==NUM_LEDS-1 load the latch counter and go to LATCH. Otherwise increment led_counter and go to FETCH.
- LATCH: count LATCH_CYCLES cycles, then go to IDLE with frame_busy=0 and led_counter=0.
- framerate in any state other than IDLE: ignored; overrun_count increments and saturates at 255.
- Arbitration:
  - A read strobe has priority.
  - A pending write is issued in any cycle where perform_read is not asserted: perform_write=1 and write_ack=1 for that cycle, with mem_address/mem_write_data taken from the write inputs.
  - If write_request and FETCH coincide, the read goes first and the write issues the next cycle.
  - Worst-case write latency is 2 cycles.
  - perform_read and perform_write are never both 1.
- write_ack is never asserted without write_request. A request dropped before ack is discarded.
- Stray encoder done outside WAIT_DONE: ignored. read_data_ready outside WAIT_DATA: ignored.
- Mid-frame reset: immediate return to IDLE. The next framerate restarts at LED 0.

Optional Feature:
- WRITE_FRAME_LOCK_EN defined: writes are granted only while frame_busy=0 (IDLE). The cycle of the framerate pulse counts as busy, so a coincident write waits until after the latch. This gives tear-free frames.
- Not defined: writes interleave as described under Arbitration.

Test Plan:
- NUM_LEDS=3, LATCH_CYCLES=10, 1-cycle memory, encoder done 20 cycles after start:
  - framerate -> perform_read at addresses 0,1,2, exactly 3 encoder_start pulses.
  - frame_busy drops 10 cycles after the 3rd done; led_counter back to 0.
- write_request at 0x005/0xABCDEF issued in the same cycle as FETCH -> perform_read that cycle; perform_write+write_ack with 0x005/0xABCDEF the next cycle; never both strobes high.
- 300 framerate pulses during one busy frame -> overrun_count=255 and frame completes normally.
- reset_n low during WAIT_DONE of LED 1, then release plus framerate -> next read at address 0, all outputs at reset values in between.
- WRITE_FRAME_LOCK_EN: write_request raised at LED 1 -> write_ack only after frame_busy falls. Without the macro, ack arrives within 2 cycles.
